// File: rtl/csr_cpuif_arbiter.sv
// csr_cpuif_arbiter: lets two requesters share one CSR cpuif port.
// One transaction is held at a time. Grants are round-robin between the
// two requesters. Each held access is issued, tracked until its ack, and
// bounded by a watchdog that forces an error ack.
//
// Handshake: a requester holds rN_req_i and its fields stable until it
// sees both rN_req_stall_*_o low in a cycle; that cycle is the accept.
// Downstream, m_req_o is held with stable fields until the stall for the
// held direction is low; that cycle is the accept. Acks are single-cycle
// pulses and carry no backpressure.
module csr_cpuif_arbiter #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  hclk_i,
  input  logic                  hrst_i,
  input  logic                  r0_req_i,
  input  logic                  r0_req_is_wr_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [DATA_WIDTH-1:0] r0_wr_data_i,
  input  logic [DATA_WIDTH-1:0] r0_wr_biten_i,
  output logic                  r0_req_stall_wr_o,
  output logic                  r0_req_stall_rd_o,
  output logic                  r0_rd_ack_o,
  output logic                  r0_rd_err_o,
  output logic [DATA_WIDTH-1:0] r0_rd_data_o,
  output logic                  r0_wr_ack_o,
  output logic                  r0_wr_err_o,
  input  logic                  r1_req_i,
  input  logic                  r1_req_is_wr_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [DATA_WIDTH-1:0] r1_wr_data_i,
  input  logic [DATA_WIDTH-1:0] r1_wr_biten_i,
  output logic                  r1_req_stall_wr_o,
  output logic                  r1_req_stall_rd_o,
  output logic                  r1_rd_ack_o,
  output logic                  r1_rd_err_o,
  output logic [DATA_WIDTH-1:0] r1_rd_data_o,
  output logic                  r1_wr_ack_o,
  output logic                  r1_wr_err_o,
  output logic                  m_req_o,
  output logic                  m_req_is_wr_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [DATA_WIDTH-1:0] m_wr_data_o,
  output logic [DATA_WIDTH-1:0] m_wr_biten_o,
  input  logic                  m_req_stall_wr_i,
  input  logic                  m_req_stall_rd_i,
  input  logic                  m_rd_ack_i,
  input  logic                  m_rd_err_i,
  input  logic [DATA_WIDTH-1:0] m_rd_data_i,
  input  logic                  m_wr_ack_i,
  input  logic                  m_wr_err_i,
  output logic [1:0]            state_dbg_o
);

  // A zero timeout still needs a one-bit counter to keep widths legal.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  hold_wr_q, hold_wr_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
  logic [DATA_WIDTH-1:0] hold_biten_q, hold_biten_d;
  logic [CW-1:0]         wd_cnt_q, wd_cnt_d;

  logic                  gnt;
  logic                  gnt_valid;
  logic                  dir_stall;
  logic                  taken;
  logic                  rd_hit, wr_hit, timeout;
  logic                  rsp_rd_ack, rsp_rd_err, rsp_wr_ack, rsp_wr_err;
  logic [DATA_WIDTH-1:0] rsp_rd_data;

  assign state_dbg_o   = state_q;
  assign m_req_o       = (state_q == ST_ISSUE);
  assign m_req_is_wr_o = hold_wr_q;
  assign m_addr_o      = hold_addr_q;
  assign m_wr_data_o   = hold_wdata_q;
  assign m_wr_biten_o  = hold_biten_q;

  // Round-robin pick and ack qualification for the held transaction.
  always_comb begin
    gnt_valid = (state_q == ST_IDLE) && !hrst_i && (r0_req_i || r1_req_i);
    gnt       = 1'b0;
    if (r0_req_i && r1_req_i) gnt = ~last_q;
    else                      gnt = r1_req_i;
    dir_stall = hold_wr_q ? m_req_stall_wr_i : m_req_stall_rd_i;
    taken     = (state_q == ST_WAIT) || ((state_q == ST_ISSUE) && !dir_stall);
    rd_hit    = !hrst_i && taken && !hold_wr_q && m_rd_ack_i;
    wr_hit    = !hrst_i && taken && hold_wr_q && m_wr_ack_i;
    timeout   = WD_EN && !hrst_i && (state_q != ST_IDLE) && (wd_cnt_q == TO_VAL)
                && !rd_hit && !wr_hit;
    rsp_rd_ack  = rd_hit || (timeout && !hold_wr_q);
    rsp_rd_err  = (rd_hit && m_rd_err_i) || (timeout && !hold_wr_q);
    rsp_rd_data = rd_hit ? m_rd_data_i : '0;
    rsp_wr_ack  = wr_hit || (timeout && hold_wr_q);
    rsp_wr_err  = (wr_hit && m_wr_err_i) || (timeout && hold_wr_q);
  end

  // Route responses to the owner only; stalls drop only for this cycle's winner.
  always_comb begin
    r0_req_stall_wr_o = !(gnt_valid && !gnt);
    r0_req_stall_rd_o = !(gnt_valid && !gnt);
    r1_req_stall_wr_o = !(gnt_valid && gnt);
    r1_req_stall_rd_o = !(gnt_valid && gnt);
    r0_rd_ack_o  = !owner_q && rsp_rd_ack;
    r0_rd_err_o  = !owner_q && rsp_rd_err;
    r0_rd_data_o = !owner_q ? rsp_rd_data : '0;
    r0_wr_ack_o  = !owner_q && rsp_wr_ack;
    r0_wr_err_o  = !owner_q && rsp_wr_err;
    r1_rd_ack_o  = owner_q && rsp_rd_ack;
    r1_rd_err_o  = owner_q && rsp_rd_err;
    r1_rd_data_o = owner_q ? rsp_rd_data : '0;
    r1_wr_ack_o  = owner_q && rsp_wr_ack;
    r1_wr_err_o  = owner_q && rsp_wr_err;
  end

  // Next-state: capture on grant, advance on accept, retire on ack or timeout.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    hold_wr_d    = hold_wr_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_biten_d = hold_biten_q;
    wd_cnt_d     = wd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt;
          last_d       = gnt;
          hold_wr_d    = gnt ? r1_req_is_wr_i : r0_req_is_wr_i;
          hold_addr_d  = gnt ? r1_addr_i      : r0_addr_i;
          hold_wdata_d = gnt ? r1_wr_data_i   : r0_wr_data_i;
          hold_biten_d = gnt ? r1_wr_biten_i  : r0_wr_biten_i;
          wd_cnt_d     = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        wd_cnt_d = wd_cnt_q + CW'(1);
        if (rd_hit || wr_hit || timeout)         state_d = ST_IDLE;
        else if (state_q == ST_ISSUE && !dir_stall) state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any held transaction.
  always_ff @(posedge hclk_i) begin
    if (hrst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      hold_wr_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_biten_q <= '0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      hold_wr_q    <= hold_wr_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_biten_q <= hold_biten_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_csr_cpuif_arbiter.sv
// Bench for csr_cpuif_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_csr_cpuif_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] biten;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic hclk_i = 1'b0;
  logic hrst_i = 1'b1;
  always #5 hclk_i = ~hclk_i;

  // ---------------- requester side ----------------
  logic [1:0]    req_v = '0;
  logic [1:0]    wr_v = '0;
  logic [AW-1:0] addr_v [2] = '{default: '0};
  logic [DW-1:0] wdata_v [2] = '{default: '0};
  logic [DW-1:0] biten_v [2] = '{default: '0};

  logic r0_req_stall_wr_o, r0_req_stall_rd_o, r0_rd_ack_o, r0_rd_err_o, r0_wr_ack_o, r0_wr_err_o;
  logic r1_req_stall_wr_o, r1_req_stall_rd_o, r1_rd_ack_o, r1_rd_err_o, r1_wr_ack_o, r1_wr_err_o;
  logic [DW-1:0] r0_rd_data_o, r1_rd_data_o;

  // ---------------- downstream side ----------------
  logic          m_req_o, m_req_is_wr_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wr_data_o, m_wr_biten_o;
  logic          m_req_stall_wr_i = 0, m_req_stall_rd_i = 0;
  logic          m_rd_ack_i = 0, m_rd_err_i = 0, m_wr_ack_i = 0, m_wr_err_i = 0;
  logic [DW-1:0] m_rd_data_i = '0;
  logic [1:0]    state_dbg_o;

  csr_cpuif_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .hclk_i(hclk_i), .hrst_i(hrst_i),
    .r0_req_i(req_v[0]), .r0_req_is_wr_i(wr_v[0]), .r0_addr_i(addr_v[0]),
    .r0_wr_data_i(wdata_v[0]), .r0_wr_biten_i(biten_v[0]),
    .r0_req_stall_wr_o(r0_req_stall_wr_o), .r0_req_stall_rd_o(r0_req_stall_rd_o),
    .r0_rd_ack_o(r0_rd_ack_o), .r0_rd_err_o(r0_rd_err_o), .r0_rd_data_o(r0_rd_data_o),
    .r0_wr_ack_o(r0_wr_ack_o), .r0_wr_err_o(r0_wr_err_o),
    .r1_req_i(req_v[1]), .r1_req_is_wr_i(wr_v[1]), .r1_addr_i(addr_v[1]),
    .r1_wr_data_i(wdata_v[1]), .r1_wr_biten_i(biten_v[1]),
    .r1_req_stall_wr_o(r1_req_stall_wr_o), .r1_req_stall_rd_o(r1_req_stall_rd_o),
    .r1_rd_ack_o(r1_rd_ack_o), .r1_rd_err_o(r1_rd_err_o), .r1_rd_data_o(r1_rd_data_o),
    .r1_wr_ack_o(r1_wr_ack_o), .r1_wr_err_o(r1_wr_err_o),
    .m_req_o(m_req_o), .m_req_is_wr_o(m_req_is_wr_o), .m_addr_o(m_addr_o),
    .m_wr_data_o(m_wr_data_o), .m_wr_biten_o(m_wr_biten_o),
    .m_req_stall_wr_i(m_req_stall_wr_i), .m_req_stall_rd_i(m_req_stall_rd_i),
    .m_rd_ack_i(m_rd_ack_i), .m_rd_err_i(m_rd_err_i), .m_rd_data_i(m_rd_data_i),
    .m_wr_ack_i(m_wr_ack_i), .m_wr_err_i(m_wr_err_i),
    .state_dbg_o(state_dbg_o)
  );

  // Per-requester views of the DUT outputs.
  logic [1:0]    stall_wr_v, stall_rd_v, rd_ack_v, rd_err_v, wr_ack_v, wr_err_v;
  logic [DW-1:0] rd_data_v [2];
  assign stall_wr_v = {r1_req_stall_wr_o, r0_req_stall_wr_o};
  assign stall_rd_v = {r1_req_stall_rd_o, r0_req_stall_rd_o};
  assign rd_ack_v   = {r1_rd_ack_o, r0_rd_ack_o};
  assign rd_err_v   = {r1_rd_err_o, r0_rd_err_o};
  assign wr_ack_v   = {r1_wr_ack_o, r0_wr_ack_o};
  assign wr_err_v   = {r1_wr_err_o, r0_wr_err_o};
  assign rd_data_v[0] = r0_rd_data_o;
  assign rd_data_v[1] = r1_rd_data_o;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model / scoreboard ----------------
  // The model tracks the single outstanding transaction as a record in
  // exp_q plus whether downstream has taken it and how long it has lived.
  txn_t exp_q[$];
  int   grants[$];
  bit   m_busy = 0;
  bit   m_acc  = 0;
  int   m_own  = 0;
  int   m_last = 1;
  int   m_age  = 0;
  logic [1:0] acc_seen = '0;

  always @(negedge hclk_i) begin
    logic [1:0]    e_stall, e_rack, e_rerr, e_wack, e_werr;
    logic [DW-1:0] e_rdata [2];
    int   g;
    bit   dstall, hit, tout;
    txn_t t;
    e_stall = 2'b11; e_rack = '0; e_rerr = '0; e_wack = '0; e_werr = '0;
    e_rdata[0] = '0; e_rdata[1] = '0;
    g = -1; hit = 0; tout = 0; dstall = 0;
    for (int i = 0; i < 2; i++)
      acc_seen[i] = req_v[i] && !stall_wr_v[i] && !stall_rd_v[i];
    if (!hrst_i) begin
      if (!m_busy) begin
        if (req_v == 2'b11) g = (m_last == 0) ? 1 : 0;
        else if (req_v != 2'b00) g = req_v[1] ? 1 : 0;
        if (g >= 0) e_stall[g] = 1'b0;
        check("m_req_idle", m_req_o, 0);
      end else begin
        t = exp_q[0];
        dstall = t.wr ? m_req_stall_wr_i : m_req_stall_rd_i;
        check("m_req", m_req_o, !m_acc);
        if (!m_acc) begin
          check("m_is_wr", m_req_is_wr_o, t.wr);
          check("m_addr",  m_addr_o, t.addr);
          check("m_wdata", m_wr_data_o, t.data);
          check("m_biten", m_wr_biten_o, t.biten);
        end
        hit  = (m_acc || !dstall) && (t.wr ? m_wr_ack_i : m_rd_ack_i);
        tout = !hit && (m_age == TO);
        if (hit || tout) begin
          if (t.wr) begin
            e_wack[m_own] = 1'b1;
            e_werr[m_own] = hit ? m_wr_err_i : 1'b1;
          end else begin
            e_rack[m_own]  = 1'b1;
            e_rerr[m_own]  = hit ? m_rd_err_i : 1'b1;
            e_rdata[m_own] = hit ? m_rd_data_i : '0;
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("r%0d_stall_wr", i), stall_wr_v[i], e_stall[i]);
      check($sformatf("r%0d_stall_rd", i), stall_rd_v[i], e_stall[i]);
      check($sformatf("r%0d_rd_ack", i),   rd_ack_v[i],   e_rack[i]);
      check($sformatf("r%0d_rd_err", i),   rd_err_v[i],   e_rerr[i]);
      check($sformatf("r%0d_rd_data", i),  rd_data_v[i],  e_rdata[i]);
      check($sformatf("r%0d_wr_ack", i),   wr_ack_v[i],   e_wack[i]);
      check($sformatf("r%0d_wr_err", i),   wr_err_v[i],   e_werr[i]);
    end
    // advance the model to the next cycle
    if (hrst_i) begin
      m_busy = 0; m_last = 1; exp_q.delete();
    end else if (m_busy) begin
      if (hit || tout) begin
        m_busy = 0;
        void'(exp_q.pop_front());
      end else begin
        m_age++;
        if (!m_acc && !dstall) m_acc = 1;
      end
    end else if (g >= 0) begin
      t.wr = wr_v[g]; t.addr = addr_v[g]; t.data = wdata_v[g]; t.biten = biten_v[g];
      exp_q.push_back(t);
      grants.push_back(g);
      m_busy = 1; m_acc = 0; m_age = 0; m_own = g; m_last = g;
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one cycle; a requester drops its request once it was accepted.
  task automatic tick();
    @(posedge hclk_i);
    #1;
    for (int i = 0; i < 2; i++) if (acc_seen[i]) req_v[i] = 1'b0;
  endtask

  task automatic new_txn(input int i, input bit wr);
    req_v[i]   = 1'b1;
    wr_v[i]    = wr;
    addr_v[i]  = AW'($urandom_range(0, (1 << AW) - 1));
    wdata_v[i] = $urandom;
    biten_v[i] = $urandom;
  endtask

  task automatic ds_idle();
    m_req_stall_wr_i = 0; m_req_stall_rd_i = 0;
    m_rd_ack_i = 0; m_rd_err_i = 0; m_wr_ack_i = 0; m_wr_err_i = 0;
    m_rd_data_i = '0;
  endtask

  // Let every pending request finish with an always-ready downstream.
  task automatic drain();
    int n = 0;
    ds_idle();
    m_rd_ack_i = 1; m_wr_ack_i = 1;
    while ((req_v != 0 || m_busy) && n < 30) begin
      tick();
      n++;
    end
    check("drain_done", (req_v == 0 && !m_busy), 1);
    ds_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] dval;
    // reset values
    hrst_i = 1;
    repeat (3) tick();
    check("rst_m_req",   m_req_o, 0);
    check("rst_m_is_wr", m_req_is_wr_o, 0);
    check("rst_m_addr",  m_addr_o, 0);
    check("rst_m_wdata", m_wr_data_o, 0);
    check("rst_m_biten", m_wr_biten_o, 0);
    hrst_i = 0;

    // simultaneous continuous writes alternate starting with r0
    grants.delete();
    m_wr_ack_i = 1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 2; i++) if (!req_v[i]) new_txn(i, 1);
      tick();
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_grant%0d", k), (grants.size() > k) ? grants[k] : -1, k % 2);
    drain();

    // single read with combinational downstream
    new_txn(0, 0);
    addr_v[0] = 12'h010;
    m_rd_ack_i = 1; m_rd_data_i = 32'hDEADBEEF;
    tick();
    #3;
    check("single_m_addr",  m_addr_o, 32'h10);
    check("single_rd_ack",  r0_rd_ack_o, 1);
    check("single_rd_data", r0_rd_data_o, 32'hDEADBEEF);
    check("single_r1_quiet", {r1_rd_ack_o, r1_rd_err_o, r1_wr_ack_o, r1_wr_err_o}, 0);
    check("single_r1_data", r1_rd_data_o, 0);
    tick();
    ds_idle();

    // downstream stall on an r1 read while r0 waits
    new_txn(1, 0);
    dval = $urandom;
    m_req_stall_rd_i = 1; m_rd_ack_i = 1; m_rd_data_i = dval;
    tick();
    new_txn(0, 1);
    for (int k = 0; k < 3; k++) begin
      #3;
      check("stall_m_req", m_req_o, 1);
      check("stall_r0_held", r0_req_stall_wr_o, 1);
      check("stall_no_ack", r1_rd_ack_o, 0);
      tick();
    end
    m_req_stall_rd_i = 0;
    #3;
    check("stall_m_req_last", m_req_o, 1);
    check("stall_r0_last", r0_req_stall_wr_o, 1);
    check("stall_ack", r1_rd_ack_o, 1);
    check("stall_data", r1_rd_data_o, dval);
    tick();
    #3;
    check("stall_m_req_done", m_req_o, 0);
    drain();

    // watchdog: no ack ever arrives
    new_txn(0, 1);
    tick();
    for (int k = 0; k < TO; k++) begin
      #3;
      check("wd_no_ack_yet", r0_wr_ack_o, 0);
      tick();
    end
    #3;
    check("wd_ack", r0_wr_ack_o, 1);
    check("wd_err", r0_wr_err_o, 1);
    tick();
    m_wr_ack_i = 1;
    #3;
    check("wd_late_ack", r0_wr_ack_o, 0);
    tick();
    ds_idle();

    // reset while waiting for an ack
    new_txn(1, 0);
    tick();
    tick();
    hrst_i = 1; m_rd_ack_i = 1;
    #3;
    check("rstmid_no_ack", r1_rd_ack_o, 0);
    tick();
    hrst_i = 0; m_rd_ack_i = 0;
    #3;
    check("rstmid_m_req", m_req_o, 0);
    check("rstmid_m_addr", m_addr_o, 0);
    grants.delete();
    new_txn(0, 1); new_txn(1, 1);
    m_wr_ack_i = 1;
    tick();
    check("rstmid_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    drain();

    // ack of the wrong direction while a write is held
    new_txn(0, 1);
    m_rd_ack_i = 1;
    tick();
    for (int k = 0; k < 3; k++) begin
      #3;
      check("wrongdir_m_req", m_req_o, (k == 0));
      check("wrongdir_wr_ack", r0_wr_ack_o, 0);
      check("wrongdir_rd_ack", r0_rd_ack_o, 0);
      tick();
    end
    m_wr_ack_i = 1;
    #3;
    check("wrongdir_final_ack", r0_wr_ack_o, 1);
    tick();
    drain();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++)
        if (!req_v[i] && $urandom_range(0, 1) == 1) new_txn(i, $urandom_range(0, 1) == 1);
      m_req_stall_wr_i = ($urandom_range(0, 3) == 0);
      m_req_stall_rd_i = ($urandom_range(0, 3) == 0);
      m_rd_ack_i  = ($urandom_range(0, 2) == 0);
      m_wr_ack_i  = ($urandom_range(0, 2) == 0);
      m_rd_err_i  = ($urandom_range(0, 3) == 0);
      m_wr_err_i  = ($urandom_range(0, 3) == 0);
      m_rd_data_i = $urandom;
      hrst_i      = ($urandom_range(0, 399) == 0);
      tick();
    end
    hrst_i = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
